// File: rtl/u_rec_fifo.sv
// Receive-side byte FIFO behind the UART receiver: qualifies the ready edge,
// stores completed bytes first-word-fall-through and flags overflow drops.
module u_rec_fifo #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned MIN_LOW = 64
) (
    input  logic              sys_clk,
    input  logic              sys_rstH,
    input  logic [7:0]        rec_dataH,
    input  logic              rec_readyH,
    input  logic              rd_enH,
    output logic [7:0]        rd_dataH,
    output logic              emptyH,
    output logic              fullH,
    output logic [ADDR_W:0]   countH,
    output logic              overrunH,
    input  logic              clr_ovrH
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rdy_d;
    logic [7:0]        low_cnt;

    logic              wr_evt;
    logic              rd_ok;
    logic              wr_ok;
    logic              drop;
    logic [ADDR_W:0]   count_nxt;

    // Only a rising ready edge after a long-enough low phase is a real byte;
    // short lows after reset or a false start are ignored.
    assign wr_evt = rec_readyH & ~rdy_d & (low_cnt >= 8'(MIN_LOW));
    assign rd_ok  = rd_enH & ~emptyH;
    assign wr_ok  = wr_evt & (~fullH | rd_ok);
    assign drop   = wr_evt & fullH & ~rd_ok;

    assign rd_dataH = mem[rd_ptr];

    always_comb begin
        count_nxt = countH;
        if (wr_ok && !rd_ok) begin
            count_nxt = countH + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = countH - CNT_W'(1);
        end
    end

    // Edge qualifier state
    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            rdy_d   <= 1'b1;
            low_cnt <= 8'd0;
        end else begin
            rdy_d <= rec_readyH;
            if (rec_readyH) begin
                low_cnt <= 8'd0;
            end else if (low_cnt != 8'hFF) begin
                low_cnt <= low_cnt + 8'd1;
            end
        end
    end

    // Storage array is not reset; stale contents are unreachable once count is 0.
    always_ff @(posedge sys_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= rec_dataH;
        end
    end

    // Pointers, occupancy flags and sticky overrun
    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            countH   <= '0;
            emptyH   <= 1'b1;
            fullH    <= 1'b0;
            overrunH <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            countH <= count_nxt;
            emptyH <= (count_nxt == CNT_W'(0));
            fullH  <= (count_nxt == CNT_W'(DEPTH));
            if (drop) begin
                overrunH <= 1'b1;
            end else if (clr_ovrH) begin
                overrunH <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_u_rec_fifo.sv
// Directed bench for u_rec_fifo: qualifier filtering, FIFO order, full/overrun cases.
module tb_u_rec_fifo;

    logic       sys_clk = 1'b0;
    logic       sys_rstH;
    logic [7:0] rec_dataH;
    logic       rec_readyH;
    logic       rd_enH;
    logic [7:0] rd_dataH;
    logic       emptyH;
    logic       fullH;
    logic [3:0] countH;
    logic       overrunH;
    logic       clr_ovrH;

    int compared   = 0;
    int mismatched = 0;

    u_rec_fifo #(.ADDR_W(3), .MIN_LOW(64)) dut (
        .sys_clk    (sys_clk),
        .sys_rstH   (sys_rstH),
        .rec_dataH  (rec_dataH),
        .rec_readyH (rec_readyH),
        .rd_enH     (rd_enH),
        .rd_dataH   (rd_dataH),
        .emptyH     (emptyH),
        .fullH      (fullH),
        .countH     (countH),
        .overrunH   (overrunH),
        .clr_ovrH   (clr_ovrH)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one clock; outputs are observed and inputs changed 1ns after the edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Receive one frame: ready low for 'low' cycles, then the rising edge.
    // Optional pop and overrun-clear are presented on the edge cycle.
    task automatic frame(input logic [7:0] b, input int low, input logic rd, input logic clr);
        rec_dataH  = b;
        rec_readyH = 1'b0;
        repeat (low) step();
        rec_readyH = 1'b1;
        rd_enH     = rd;
        clr_ovrH   = clr;
        step();
        rd_enH     = 1'b0;
        clr_ovrH   = 1'b0;
        step();
    endtask

    task automatic pop();
        rd_enH = 1'b1;
        step();
        rd_enH = 1'b0;
    endtask

    task automatic test_reset();
        sys_rstH   = 1'b1;
        rec_readyH = 1'b1;
        rec_dataH  = 8'h00;
        rd_enH     = 1'b0;
        clr_ovrH   = 1'b0;
        step();
        step();
        sys_rstH   = 1'b0;
        rec_readyH = 1'b0;
        step();
        rec_readyH = 1'b1;
        step();
        step();
        compared++;
        if (emptyH !== 1'b1) begin mismatched++; $display("FAIL reset_empty got %b exp 1", emptyH); end
        compared++;
        if (countH !== 4'd0) begin mismatched++; $display("FAIL reset_count got %0d exp 0", countH); end
        compared++;
        if (fullH !== 1'b0 || overrunH !== 1'b0) begin
            mismatched++; $display("FAIL reset_flags got full=%b ovr=%b exp 0/0", fullH, overrunH);
        end
    endtask

    task automatic test_false_start();
        frame(8'hA5, 5, 1'b0, 1'b0);
        compared++;
        if (emptyH !== 1'b1 || countH !== 4'd0) begin
            mismatched++; $display("FAIL false_start got empty=%b cnt=%0d exp 1/0", emptyH, countH);
        end
        frame(8'hA6, 63, 1'b0, 1'b0);
        compared++;
        if (countH !== 4'd0) begin mismatched++; $display("FAIL low63 got cnt=%0d exp 0", countH); end
    endtask

    task automatic test_single();
        rec_dataH  = 8'h3C;
        rec_readyH = 1'b0;
        repeat (150) step();
        rec_readyH = 1'b1;
        step();
        compared++;
        if (emptyH !== 1'b0 || countH !== 4'd1 || rd_dataH !== 8'h3C) begin
            mismatched++;
            $display("FAIL single_write got empty=%b cnt=%0d data=%h exp 0/1/3c", emptyH, countH, rd_dataH);
        end
        repeat (3) step();
        compared++;
        if (countH !== 4'd1) begin mismatched++; $display("FAIL held_high got cnt=%0d exp 1", countH); end
        pop();
        compared++;
        if (emptyH !== 1'b1 || countH !== 4'd0) begin
            mismatched++; $display("FAIL single_pop got empty=%b cnt=%0d exp 1/0", emptyH, countH);
        end
        pop();
        compared++;
        if (emptyH !== 1'b1 || countH !== 4'd0) begin
            mismatched++; $display("FAIL pop_empty got empty=%b cnt=%0d exp 1/0", emptyH, countH);
        end
        frame(8'h4D, 64, 1'b0, 1'b0);
        compared++;
        if (countH !== 4'd1 || rd_dataH !== 8'h4D) begin
            mismatched++; $display("FAIL low64 got cnt=%0d data=%h exp 1/4d", countH, rd_dataH);
        end
        pop();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) frame(8'(i), 70, 1'b0, 1'b0);
        compared++;
        if (fullH !== 1'b1 || countH !== 4'd8 || overrunH !== 1'b1) begin
            mismatched++;
            $display("FAIL overflow got full=%b cnt=%0d ovr=%b exp 1/8/1", fullH, countH, overrunH);
        end
        for (int i = 1; i <= 8; i++) begin
            compared++;
            if (rd_dataH !== 8'(i)) begin
                mismatched++; $display("FAIL overflow_rd%0d got %h exp %h", i, rd_dataH, 8'(i));
            end
            pop();
        end
        compared++;
        if (emptyH !== 1'b1) begin mismatched++; $display("FAIL overflow_drained got empty=%b exp 1", emptyH); end
        clr_ovrH = 1'b1;
        step();
        clr_ovrH = 1'b0;
        compared++;
        if (overrunH !== 1'b0) begin mismatched++; $display("FAIL ovr_clear got %b exp 0", overrunH); end
    endtask

    task automatic test_full_rw();
        logic [7:0] last;
        for (int i = 0; i < 8; i++) frame(8'h11 + 8'(i), 70, 1'b0, 1'b0);
        frame(8'h55, 70, 1'b1, 1'b0);
        compared++;
        if (countH !== 4'd8 || fullH !== 1'b1 || overrunH !== 1'b0) begin
            mismatched++;
            $display("FAIL full_rw got cnt=%0d full=%b ovr=%b exp 8/1/0", countH, fullH, overrunH);
        end
        compared++;
        if (rd_dataH !== 8'h12) begin mismatched++; $display("FAIL full_rw_head got %h exp 12", rd_dataH); end
        last = 8'h00;
        for (int i = 0; i < 8; i++) begin
            last = rd_dataH;
            pop();
        end
        compared++;
        if (last !== 8'h55) begin mismatched++; $display("FAIL full_rw_last got %h exp 55", last); end
        compared++;
        if (emptyH !== 1'b1) begin mismatched++; $display("FAIL full_rw_empty got %b exp 1", emptyH); end
    endtask

    task automatic test_sticky();
        for (int i = 0; i < 8; i++) frame(8'h21 + 8'(i), 70, 1'b0, 1'b0);
        frame(8'h77, 70, 1'b0, 1'b1);
        compared++;
        if (overrunH !== 1'b1 || countH !== 4'd8) begin
            mismatched++; $display("FAIL sticky_set got ovr=%b cnt=%0d exp 1/8", overrunH, countH);
        end
        clr_ovrH = 1'b1;
        step();
        clr_ovrH = 1'b0;
        compared++;
        if (overrunH !== 1'b0) begin mismatched++; $display("FAIL sticky_clr got %b exp 0", overrunH); end
        compared++;
        if (rd_dataH !== 8'h21) begin mismatched++; $display("FAIL sticky_head got %h exp 21", rd_dataH); end
    endtask

    task automatic test_mid_reset();
        sys_rstH = 1'b1;
        step();
        sys_rstH = 1'b0;
        compared++;
        if (countH !== 4'd0 || emptyH !== 1'b1 || fullH !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset got cnt=%0d empty=%b full=%b exp 0/1/0", countH, emptyH, fullH);
        end
        frame(8'h9E, 70, 1'b0, 1'b0);
        compared++;
        if (countH !== 4'd1 || rd_dataH !== 8'h9E) begin
            mismatched++; $display("FAIL post_reset got cnt=%0d data=%h exp 1/9e", countH, rd_dataH);
        end
    endtask

    initial begin
        test_reset();
        test_false_start();
        test_single();
        test_overflow();
        test_full_rw();
        test_sticky();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/u_rec_fifo.md
Name: u_rec_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver.
- Qualifies the receiver's ready level, captures each completed byte and holds it in an N-deep FIFO until the host pops it.
- Filters the spurious ready edges the receiver produces after reset and after aborted (false) start bits.
- Flags bytes lost to overflow with a sticky overrun bit.

Parameters:
- ADDR_W, 3, FIFO address width; DEPTH = 2**ADDR_W entries (default 8).
- MIN_LOW, 64, minimum consecutive cycles rec_readyH must be low before its rising edge counts as a new byte; legal range 1..255.

Ports:
- sys_clk  in  1  system clock, same clock as the UART receiver.
- sys_rstH  in  1  synchronous reset, active high.
- rec_dataH  in  8  parallel byte from the receiver; stable when rec_readyH rises after a frame.
- rec_readyH  in  1  receiver ready level.
  - High while the receiver is idle.
  - Low during a frame.
  - Rises one cycle after the stop-bit check.
- rd_enH  in  1  host pop request, one byte per cycle.
- rd_dataH  out  8  head-of-FIFO byte (first-word fall-through); valid when emptyH=0.
- emptyH  out  1  FIFO empty.
- fullH  out  1  FIFO full.
- countH  out  ADDR_W+1  number of stored bytes, 0..DEPTH.
- overrunH  out  1  sticky; a qualified byte was dropped.
- clr_ovrH  in  1  clears overrunH.

Behaviour:
- Reset (sys_rstH=1 at a sys_clk edge) sets:
  - pointers = 0, countH = 0, emptyH = 1, fullH = 0, overrunH = 0;
  - rdy_d (delayed rec_readyH) = 1, low_cnt = 0.
- Reset mid-operation discards all stored bytes. FIFO memory contents need not be cleared.
- Edge qualifier:
  - low_cnt is an 8-bit counter that saturates at 255.
  - When rec_readyH=0: low_cnt <= low_cnt+1 (saturating).
  - When rec_readyH=1: low_cnt <= 0.
  - rdy_d <= rec_readyH every cycle.
  - wr_evt = rec_readyH & ~rdy_d & (low_cnt >= MIN_LOW), evaluated combinationally on the current registered low_cnt.
- Why the qualifier is needed:
  - The receiver drives ready low for 1 cycle after reset, and for about 5 cycles on a false start. Neither may produce a write.
  - A real frame holds ready low for well over 100 cycles.
- Write:
  - On wr_evt, rec_dataH is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
  - Exactly one write per qualified edge. A held-high ready never re-writes.
- Read:
  - rd_dataH = mem[rd_ptr] combinationally.
  - On rd_enH with emptyH=0, rd_ptr increments (wrapping).
  - rd_enH while empty is ignored; no pointer or count change.
- Count and flags:
  - countH <= countH + write_accepted - read_accepted.
  - emptyH = (countH==0), fullH = (countH==DEPTH), both registered-derived.
  - Latency: emptyH falls and the byte appears on rd_dataH the cycle after wr_evt.
- Full handling:
  - wr_evt while full and no read: byte dropped, pointers unchanged, overrunH <= 1.
  - wr_evt while full with a simultaneous valid read: both occur, countH stays at DEPTH, no overrun.
- Simultaneous write and read when non-empty and non-full: both occur, countH unchanged.
- Overrun:
  - clr_ovrH=1 clears overrunH next cycle.
  - If a drop occurs in the same cycle as clr_ovrH, set wins and overrunH stays 1.
- Pointer wrap: DEPTH writes then DEPTH reads return bytes in order, across the wrap.

Test Plan:
- Release reset with rec_readyH going 0 (1 cycle) then 1 -> no write; emptyH=1, countH=0.
- Hold rec_readyH low 5 cycles then high (false start), rec_dataH=8'hA5 -> no write; emptyH stays 1.
- Hold rec_readyH low 150 cycles, rec_dataH=8'h3C, then high -> next cycle emptyH=0, countH=1, rd_dataH=8'h3C. Pulse rd_enH -> emptyH=1.
- Fill with 9 qualified frames 8'h01..8'h09 (DEPTH=8), no reads -> fullH=1, countH=8, overrunH=1. Reading 8 bytes returns 01..08; 09 is lost.
- With FIFO full, qualified frame 8'h55 coincides with rd_enH -> countH stays 8, overrunH=0; the last byte read out is 8'h55.
- Sticky overrun: assert clr_ovrH in the same cycle as a drop -> overrunH stays 1. Assert clr_ovrH alone next cycle -> overrunH=0.
